pwm_multi: RTL

- Multi-channel PWM generator; parametrised successor to the single-channel fixed-divider PWM used in the gateware.
- One shared period counter drives CHANNELS comparators.
- Period and per-channel duty are runtime registers, double-buffered so that updates land glitch-free at the period wrap.
- Sits between the host interface register block and the output pins.

---
 rtl/pwm_multi_pkg.sv | 33 +++
 rtl/pwm_multi_if.sv | 21 ++
 rtl/pwm_multi_deadtime.sv | 59 +++++
 rtl/pwm_multi.sv | 119 +++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared constants, types and helpers for the multi-channel
// PWM generator.
//   PWM_PERIOD_DEFAULT / PWM_DUTY_DEFAULT / PWM_DEADTIME : reset-time defaults
//   count_t      : counter/period/duty word at the default width
//   duty_slice() : pulls channel ch's duty word out of a packed duty bus
package pwm_multi_pkg;

  localparam int PWM_WIDTH          = 16;
  localparam int PWM_PERIOD_DEFAULT = 255;
  localparam int PWM_DUTY_DEFAULT   = 128;
  localparam int PWM_DEADTIME       = 4;

  // Upper bounds on the parameters; the duty bus is widened to this size
  // so one helper serves every CHANNELS/WIDTH combination.
  localparam int MAX_CHANNELS = 32;
  localparam int MAX_WIDTH    = 32;
  localparam int DUTY_BUS_W   = MAX_CHANNELS * MAX_WIDTH;
  localparam int DUTY_IDX_W   = $clog2(DUTY_BUS_W);

  typedef logic [PWM_WIDTH-1:0] count_t;
  typedef logic [MAX_WIDTH-1:0] duty_word_t;

  // Returns MAX_WIDTH bits starting at channel ch; the caller keeps the low
  // 'width' bits.
  function automatic duty_word_t duty_slice(input logic [DUTY_BUS_W-1:0] bus,
                                            input int unsigned ch,
                                            input int unsigned width);
    logic [DUTY_IDX_W-1:0] idx;
    idx = DUTY_IDX_W'(ch * width);
    return bus[idx +: MAX_WIDTH];
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: configuration bus between the host register block (master)
// and the PWM generator (slave).
//   period   : new period value, sampled while load is high
//   duty     : new duty values, channel i at [i*WIDTH +: WIDTH]
//   load     : single-cycle strobe, captures period/duty into pending regs
//   load_ack : single-cycle pulse when the pending values become active
// Handshake: load is a fire-and-forget strobe with no back-pressure; the
// slave always accepts it. load_ack follows later, once the values are
// applied at a period wrap (or immediately while the generator is stopped).
interface pwm_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) ();
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      load;
  logic                      load_ack;

  modport master (output period, output duty, output load, input load_ack);
  modport slave  (input period, input duty, input load, output load_ack);
endinterface

// File: rtl/pwm_multi_deadtime.sv
// pwm_deadtime: per-channel dead-time stage (built only when
// PWM_MULTI_DEADTIME_EN is defined).
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : low forces both outputs low and clears the counter
//   r          : raw compare signal
//   hi / lo    : r and !r, each rising only after r has been stable for
//                DEADTIME cycles; shorter pulses never reach the output
`ifdef PWM_MULTI_DEADTIME_EN
module pwm_deadtime #(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic r,
  output logic hi,
  output logic lo
);
  logic       r_q;
  logic [7:0] stable_q, stable_d;
  logic       hi_q, hi_d, lo_q, lo_d;

  // stable counts cycles since r last changed, saturating at DEADTIME. A
  // change drops the active side at once; the other side rises only once
  // the counter reaches DEADTIME.
  always_comb begin
    stable_d = stable_q;
    if (r != r_q) begin
      stable_d = '0;
    end else if (stable_q != 8'(DEADTIME)) begin
      stable_d = stable_q + 8'd1;
    end
    hi_d = r && (stable_d == 8'(DEADTIME));
    lo_d = !r && (stable_d == 8'(DEADTIME));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= 1'b0;
      stable_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else if (!enable) begin
      r_q      <= 1'b0;
      stable_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      r_q      <= r;
      stable_q <= stable_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule
`endif

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator. One shared period counter drives
// CHANNELS comparators; period and duty are double-buffered and switch over
// only at the period wrap (or at once while stopped).
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : run counter; low holds counter at 0 and outputs low
//   din         : per-channel gate
//   cfg         : configuration bus (period, duty, load, load_ack)
//   cycle_start : one-cycle pulse in the cycle after the counter wraps
//   dout        : registered PWM outputs
//   dout_n      : complementary outputs, only with PWM_MULTI_DEADTIME_EN
// Build option PWM_MULTI_DEADTIME_EN adds a dead-time stage per channel.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int PERIOD_DEFAULT = PWM_PERIOD_DEFAULT,
  parameter int DUTY_DEFAULT   = PWM_DUTY_DEFAULT,
  parameter int DEADTIME       = PWM_DEADTIME
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] din,
  pwm_multi_if.slave          cfg,
  output logic                cycle_start,
  output logic [CHANNELS-1:0] dout
`ifdef PWM_MULTI_DEADTIME_EN
  ,
  output logic [CHANNELS-1:0] dout_n
`endif
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || WIDTH < 1 || WIDTH > MAX_WIDTH ||
      DEADTIME < 1 || DEADTIME > 255) begin : g_param_check
    $error("pwm_multi: parameter out of range");
  end

  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      period_act_q, period_pend_q;
  logic [WIDTH-1:0]      duty_act_q  [CHANNELS];
  logic [WIDTH-1:0]      duty_pend_q [CHANNELS];
  logic [WIDTH-1:0]      duty_in     [CHANNELS];
  logic [DUTY_BUS_W-1:0] duty_wide;
  logic                  pend_q, load_ack_q, cycle_start_q;
  logic [CHANNELS-1:0]   raw_q, raw_d;
  logic                  wrap, apply;

  assign duty_wide = DUTY_BUS_W'(cfg.duty);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_duty
    assign duty_in[g] = WIDTH'(duty_slice(duty_wide, g, WIDTH));
  end

  // Pending values go live at a wrap, or on any cycle while stopped so a
  // halted generator takes new config immediately.
  always_comb begin
    wrap  = enable && (cnt_q == period_act_q);
    apply = pend_q && (wrap || !enable);
    cnt_d = (!enable || wrap) ? '0 : cnt_q + WIDTH'(1);
    raw_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw_d[i] = enable && din[i] && (cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      period_act_q  <= WIDTH'(PERIOD_DEFAULT);
      period_pend_q <= WIDTH'(PERIOD_DEFAULT);
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act_q[i]  <= WIDTH'(DUTY_DEFAULT);
        duty_pend_q[i] <= WIDTH'(DUTY_DEFAULT);
      end
      pend_q        <= 1'b0;
      load_ack_q    <= 1'b0;
      cycle_start_q <= 1'b0;
      raw_q         <= '0;
    end else begin
      cnt_q         <= cnt_d;
      raw_q         <= raw_d;
      cycle_start_q <= wrap;
      load_ack_q    <= apply;
      if (apply) begin
        period_act_q <= period_pend_q;
        for (int i = 0; i < CHANNELS; i++) duty_act_q[i] <= duty_pend_q[i];
      end
      // A load in the apply cycle refills pending and keeps the flag set,
      // so the new values land at the following wrap.
      if (cfg.load) begin
        period_pend_q <= cfg.period;
        for (int i = 0; i < CHANNELS; i++) duty_pend_q[i] <= duty_in[i];
        pend_q <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign cfg.load_ack = load_ack_q;
  assign cycle_start  = cycle_start_q;

`ifdef PWM_MULTI_DEADTIME_EN
  for (genvar g = 0; g < CHANNELS; g++) begin : g_dt
    pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .r      (raw_q[g]),
      .hi     (dout[g]),
      .lo     (dout_n[g])
    );
  end
`else
  assign dout = raw_q;
`endif

endmodule
